// File: rtl/linebuffer_multi.sv
// linebuffer_multi
// Multi-row line buffer for the convolution front end. Keeps the previous
// LINES image rows in per-line circular RAMs and, for every accepted pixel,
// emits a vertically aligned column of LINES+1 pixels: the current pixel in
// slice 0 and the pixel k rows above it (same column) in slice k.
//
// Handshake: valid_in qualifies din for one cycle; there is no ready, so
// every valid_in pixel is consumed. valid_out qualifies taps_out/col_out/
// eol_out for one cycle, one cycle after the pixel was accepted; the
// downstream stage must take every valid_out beat.
//
// The line RAMs are read and written in the same cycle at the same column
// (read-before-write). The read data from line k-1 is written straight into
// line k at that column, so the vertical shift needs no delayed write-back
// and there is no same-address hazard between consecutive pixels.

module linebuffer_multi #(
    parameter int WIDTH     = 8,
    parameter int IMG_WIDTH = 482,
    parameter int LINES     = 2,
    localparam int CW       = $clog2(IMG_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         din,
    input  logic                     valid_in,
    input  logic                     sof,
    output logic [(LINES+1)*WIDTH-1:0] taps_out,
    output logic                     valid_out,
    output logic [CW-1:0]            col_out,
    output logic                     eol_out
);

    // Width of the saturating row-fill counter (counts 0..LINES).
    localparam int RW = $clog2(LINES + 1);

    // Total width of the tap bus.
    localparam int TW = (LINES + 1) * WIDTH;

    // Constants sized to the counters they are compared against.
    localparam logic [CW-1:0] LAST_COL  = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROWS_FULL = RW'(LINES);

    // ------------------------------------------------------------------
    // Position tracking
    // ------------------------------------------------------------------

    // Column of the next pixel within its row.
    logic [CW-1:0] col_q;
    logic [CW-1:0] col_d;

    // Number of complete rows stored since frame start, saturating at LINES.
    logic [RW-1:0] rows_q;
    logic [RW-1:0] rows_d;

    // Position seen by the pixel on din this cycle. A start-of-frame
    // overrides the stored position so that a pixel arriving together with
    // sof lands at column 0 of row 0 of the new frame.
    logic [CW-1:0] eff_col;
    logic [RW-1:0] eff_rows;

    // Decodes of the effective position.
    logic          at_last_col;
    logic          primed;

    // ------------------------------------------------------------------
    // Line storage
    // ------------------------------------------------------------------

    // mem_q[0] holds the row directly above the current one, mem_q[k] the
    // row k+1 above. Contents are deliberately not reset: stale data is
    // never visible because valid_out waits for LINES fresh rows.
    logic [WIDTH-1:0] mem_q [LINES][IMG_WIDTH];

    // Read-before-write data of every line at the effective column.
    logic [WIDTH-1:0] rd_data [LINES];

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------

    logic [TW-1:0]    taps_q;
    logic [TW-1:0]    taps_d;
    logic [CW-1:0]    col_out_q;
    logic             valid_q;
    logic             valid_d;
    logic             eol_q;
    logic             eol_d;

    // Effective position of the incoming pixel and its decodes.
    always_comb begin
        eff_col     = sof ? '0 : col_q;
        eff_rows    = sof ? '0 : rows_q;
        at_last_col = (eff_col == LAST_COL);
        primed      = (eff_rows == ROWS_FULL);
    end

    // Next column and row-fill count: advance on each accepted pixel,
    // wrap the column at the end of a row and count completed rows.
    always_comb begin
        col_d  = col_q;
        rows_d = rows_q;
        if (sof) begin
            col_d  = '0;
            rows_d = '0;
        end
        if (valid_in) begin
            if (at_last_col) begin
                col_d = '0;
                if (eff_rows != ROWS_FULL) begin
                    rows_d = eff_rows + 1'b1;
                end else begin
                    rows_d = eff_rows;
                end
            end else begin
                col_d  = eff_col + 1'b1;
                rows_d = eff_rows;
            end
        end
    end

    // Position counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            rows_q <= '0;
        end else begin
            col_q  <= col_d;
            rows_q <= rows_d;
        end
    end

    // Asynchronous read of every line at the column being written.
    always_comb begin
        for (int k = 0; k < LINES; k++) begin
            rd_data[k] = mem_q[k][eff_col];
        end
    end

    // Vertical shift: the new pixel enters line 0 and each line passes its
    // old value at this column down to the next line.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            mem_q[0][eff_col] <= din;
            for (int k = 1; k < LINES; k++) begin
                mem_q[k][eff_col] <= rd_data[k-1];
            end
        end
    end

    // Assemble the tap column and the qualifiers for the accepted pixel.
    always_comb begin
        taps_d                = '0;
        taps_d[WIDTH-1:0]     = din;
        for (int k = 0; k < LINES; k++) begin
            taps_d[(k+1)*WIDTH +: WIDTH] = rd_data[k];
        end
        valid_d = valid_in && primed;
        eol_d   = valid_in && primed && at_last_col;
    end

    // Output registers: data and column hold across input gaps, while the
    // qualifiers are single-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps_q    <= '0;
            col_out_q <= '0;
            valid_q   <= 1'b0;
            eol_q     <= 1'b0;
        end else begin
            valid_q <= valid_d;
            eol_q   <= eol_d;
            if (valid_in) begin
                taps_q    <= taps_d;
                col_out_q <= eff_col;
            end
        end
    end

    assign taps_out  = taps_q;
    assign col_out   = col_out_q;
    assign valid_out = valid_q;
    assign eol_out   = eol_q;

endmodule

// File: tb/tb_linebuffer_multi.sv
// Testbench for linebuffer_multi (IMG_WIDTH=4, LINES=2, WIDTH=8).
// A frame-level reference model remembers every pixel of the current frame
// by (row, column) and predicts each output beat from that history; table
// vectors and hand-written sequences cover the directed scenarios.

module tb_linebuffer_multi;

    localparam int W  = 8;
    localparam int IW = 4;
    localparam int L  = 2;
    localparam int CW = $clog2(IW);
    localparam int TW = (L + 1) * W;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  din;
    logic          valid_in;
    logic          sof;
    logic [TW-1:0] taps_out;
    logic          valid_out;
    logic [CW-1:0] col_out;
    logic          eol_out;

    always #5 clk = ~clk;

    linebuffer_multi #(
        .WIDTH     (W),
        .IMG_WIDTH (IW),
        .LINES     (L)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .valid_in  (valid_in),
        .sof       (sof),
        .taps_out  (taps_out),
        .valid_out (valid_out),
        .col_out   (col_out),
        .eol_out   (eol_out)
    );

    // ------------------------------------------------------------------
    // Scoreboard counters
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: pixels of the current frame indexed by (row, col).
    // ------------------------------------------------------------------
    int           m_r;
    int           m_c;
    logic [W-1:0] hist [64][IW];
    bit           exp_valid;
    bit           exp_eol;
    int           exp_col;
    logic [W-1:0] exp_taps [L+1];
    bit           exp_known [L+1];

    task automatic model_reset();
        m_r       = 0;
        m_c       = 0;
        exp_valid = 0;
        exp_eol   = 0;
        exp_col   = 0;
        for (int k = 0; k <= L; k++) begin
            exp_taps[k]  = '0;
            exp_known[k] = 1;
        end
    endtask

    task automatic model_step(input bit v, input bit s, input logic [W-1:0] d);
        if (s) begin
            m_r = 0;
            m_c = 0;
        end
        if (v) begin
            hist[m_r % 64][m_c] = d;
            exp_valid = (m_r >= L);
            exp_eol   = exp_valid && (m_c == IW - 1);
            exp_col   = m_c;
            for (int k = 0; k <= L; k++) begin
                exp_known[k] = (m_r >= k);
                if (exp_known[k]) exp_taps[k] = hist[(m_r - k) % 64][m_c];
            end
            m_c++;
            if (m_c == IW) begin
                m_c = 0;
                m_r++;
            end
        end else begin
            exp_valid = 0;
            exp_eol   = 0;
        end
    endtask

    task automatic compare_model();
        check("valid_out", int'(valid_out), int'(exp_valid));
        check("eol_out", int'(eol_out), int'(exp_eol));
        check("col_out", int'(col_out), exp_col);
        for (int k = 0; k <= L; k++) begin
            if (exp_known[k]) begin
                check($sformatf("taps_slice%0d", k), int'(taps_out[k*W +: W]), int'(exp_taps[k]));
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Driver: apply one cycle of input, then compare after the edge.
    // ------------------------------------------------------------------
    task automatic step(input bit v, input bit s, input logic [W-1:0] d);
        valid_in = v;
        sof      = s;
        din      = d;
        model_step(v, s, d);
        @(posedge clk);
        #1;
        compare_model();
        valid_in = 1'b0;
        sof      = 1'b0;
    endtask

    function automatic logic [W-1:0] pix(input int r, input int c);
        return W'(r * 16 + c);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_taps"}, int'(taps_out), 0);
        check({tag, "_valid"}, int'(valid_out), 0);
        check({tag, "_col"}, int'(col_out), 0);
        check({tag, "_eol"}, int'(eol_out), 0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        valid_in = 1'b0;
        sof      = 1'b0;
        din      = '0;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ------------------------------------------------------------------
    // Directed vectors: rows 0..3 of pixel = row*16+col, sof on first pixel.
    // ------------------------------------------------------------------
    typedef struct {
        bit            v;
        bit            s;
        logic [W-1:0]  d;
        bit            e_valid;
        bit            e_eol;
        int            e_col;
        bit            chk_taps;
        logic [TW-1:0] e_taps;
    } vec_t;

    vec_t tbl [16];

    task automatic apply_table(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step(tbl[i].v, tbl[i].s, tbl[i].d);
            check($sformatf("%s_v%0d_valid", tag, i), int'(valid_out), int'(tbl[i].e_valid));
            check($sformatf("%s_v%0d_eol", tag, i), int'(eol_out), int'(tbl[i].e_eol));
            check($sformatf("%s_v%0d_col", tag, i), int'(col_out), tbl[i].e_col);
            if (tbl[i].chk_taps) begin
                check($sformatf("%s_v%0d_taps", tag, i), int'(taps_out), int'(tbl[i].e_taps));
            end
        end
    endtask

    // Stream a run of pixels with the test-plan pixel values.
    task automatic stream(input int rows, input int extra_cols, input bit with_sof);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < IW; c++) begin
                step(1'b1, with_sof && r == 0 && c == 0, pix(r, c));
            end
        end
        for (int c = 0; c < extra_cols; c++) begin
            step(1'b1, with_sof && rows == 0 && c == 0, pix(rows, c));
        end
    endtask

    logic [TW-1:0] got_q [$];
    logic [TW-1:0] exp_q [$];
    int            nvalid;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < IW; c++) begin
                int i;
                i = r * IW + c;
                tbl[i].v        = 1'b1;
                tbl[i].s        = (i == 0);
                tbl[i].d        = pix(r, c);
                tbl[i].e_valid  = (r >= 2);
                tbl[i].e_eol    = (r >= 2) && (c == IW - 1);
                tbl[i].e_col    = c;
                tbl[i].chk_taps = (r >= 2);
                tbl[i].e_taps   = (r >= 2) ? {pix(r - 2, c), pix(r - 1, c), pix(r, c)} : '0;
            end
        end

        // Reset values.
        do_reset();
        check_reset_outputs("post_reset");

        // Scenarios 1 and 3: continuous rows 0..3.
        apply_table(16, "s1");
        // Explicit landmarks re-checked from the final state of row 3.
        check("s3_last_col", int'(col_out), 3);
        check("s3_last_taps", int'(taps_out), int'(24'h132333));

        // Gap cycle: data holds, qualifiers drop.
        step(1'b0, 1'b0, 8'hee);
        check("gap_hold_taps", int'(taps_out), int'(24'h132333));
        check("gap_valid_low", int'(valid_out), 0);

        // Scenario 2: 5 rows with random gaps vs. gapless expectation.
        got_q.delete();
        exp_q.delete();
        for (int r = 2; r < 5; r++)
            for (int c = 0; c < IW; c++)
                exp_q.push_back({pix(r - 2, c), pix(r - 1, c), pix(r, c)});
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < IW; c++) begin
                for (int g = 0; g < 6 && $urandom_range(1, 0) == 1; g++) begin
                    step(1'b0, 1'b0, W'($urandom));
                    check("s2_gap_no_valid", int'(valid_out), 0);
                end
                step(1'b1, r == 0 && c == 0, pix(r, c));
                if (valid_out) got_q.push_back(taps_out);
            end
        end
        check("s2_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("s2_seq%0d", i), int'(got_q[i]), int'(exp_q[i]));
        end

        // Scenario 4: sof with a pixel at row 2 col 2.
        stream(2, 2, 1'b1);
        step(1'b1, 1'b1, 8'h00);
        check("s4_sof_col", int'(col_out), 0);
        check("s4_sof_valid", int'(valid_out), 0);
        nvalid = 0;
        for (int c = 1; c < IW; c++) begin
            step(1'b1, 1'b0, pix(0, c));
            nvalid += int'(valid_out);
        end
        for (int c = 0; c < IW; c++) begin
            step(1'b1, 1'b0, pix(1, c));
            nvalid += int'(valid_out);
        end
        check("s4_no_valid_before_row2", nvalid, 0);
        step(1'b1, 1'b0, pix(2, 0));
        check("s4_first_valid", int'(valid_out), 1);
        check("s4_first_taps", int'(taps_out), int'(24'h001020));
        check("s4_first_col", int'(col_out), 0);

        // Scenario 5: reset pulse at row 3 col 1, then replay scenario 1.
        stream(3, 1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("s5_async");
        @(posedge clk);
        #1;
        check_reset_outputs("s5_held");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        apply_table(12, "s5");

        // Scenario 6: sof alone mid-frame, then a normal frame.
        stream(1, 2, 1'b1);
        step(1'b0, 1'b1, 8'h55);
        check("s6_sof_alone_valid", int'(valid_out), 0);
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, i == 0, pix(i / IW, i % IW));
            if (i == 0) check("s6_first_col", int'(col_out), 0);
            nvalid += int'(valid_out);
        end
        check("s6_no_valid_two_rows", nvalid, 0);
        step(1'b1, 1'b0, pix(2, 0));
        check("s6_first_valid", int'(valid_out), 1);
        check("s6_first_taps", int'(taps_out), int'(24'h001020));

        // Randomized traffic with occasional start-of-frame.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(3, 0) != 0, $urandom_range(39, 0) == 0, W'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/linebuffer_multi.md
# linebuffer_multi

Parametrised multi-row line buffer for the convolution front end. It stores the previous `LINES` image rows in internal circular RAMs and presents a vertically aligned column of `LINES+1` pixels per accepted input pixel: the current row plus the `LINES` rows above it. It sits between the pixel source and the KxK window/shift-register stage, replacing chained single-line FIFO buffers. Unlike those, it generalises row count, handles `valid_in` gaps, restarts on start-of-frame, and reports column position.

## Interface
- `WIDTH`, 8: bits per pixel.
- `IMG_WIDTH`, 482: pixels per row; legal range ≥ 2.
- `LINES`, 2: stored previous rows; legal range 1..4 (window size K = `LINES+1`).
- `CW`, `$clog2(IMG_WIDTH)`: column counter width (localparam).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  WIDTH  input pixel.
- `valid_in`  in  1  `din` valid this cycle; gaps allowed at any point.
- `sof`  in  1  start of frame; may coincide with `valid_in`.
- `taps_out`  out  (LINES+1)*WIDTH  slice k = pixel from k rows above, same column; slice 0 = current pixel.
- `valid_out`  out  1  `taps_out` valid, window fully primed.
- `col_out`  out  CW  column index of `taps_out`.
- `eol_out`  out  1  qualifies the last column (`IMG_WIDTH-1`) of a row; only asserted with `valid_out`.

## Operation
- Column counter `col` runs 0..`IMG_WIDTH-1` and advances on each `valid_in`. It wraps to 0 after `IMG_WIDTH-1`, and the row-fill counter then increments.
- Row-fill counter `rows` saturates at `LINES`. The window is primed when `rows == LINES`.
- Line memories: `LINES` RAMs, each of depth `IMG_WIDTH`, addressed by `col`, with read-before-write semantics.
  - Line 1 receives `din`.
  - Line k receives the old contents of line k-1 at the same column.
  - The result is a vertical shift per column.
- Memories are not reset. Contents from a previous frame are never exposed, because `valid_out` requires priming.
- `sof`:
  - Synchronously clears `col` and `rows` in the same cycle.
  - If `valid_in` is also high, that pixel is column 0 of row 0 of the new frame and is written.
  - `sof` mid-row discards the partial row and all priming.
- `valid_in` low: no counter or memory change, and the output registers hold their values except `valid_out`/`eol_out`, which drop to 0.
- Widths: `col` is CW bits; `rows` is `$clog2(LINES+1)` bits. There are no arithmetic outputs.

## Timing
- Reset values: `taps_out` = 0, `valid_out` = 0, `col_out` = 0, `eol_out` = 0; internal `col` = 0, `rows` = 0.
- Latency: 1 cycle. A pixel accepted at edge N produces `taps_out`/`col_out` registered at edge N+1.
- `valid_out` at N+1 is 1 iff `valid_in` was 1 at N and `rows == LINES` before that pixel.
- `eol_out` at N+1 is 1 iff `valid_out` at N+1 is 1 and the pixel was at column `IMG_WIDTH-1`.
- Back-to-back `valid_in` sustains 1 output per cycle, with no bubbles at row wrap.
- Same-column hazard: none. Consecutive accesses hit consecutive addresses. A pipelined write-back of line k-1 data to line k at the delayed address must use the delayed column.
- `rst_n` deasserted mid-frame: everything restarts unprimed. The first `LINES` full rows after reset produce no `valid_out`.
- No backpressure: the consumer must accept every `valid_out` cycle.

## Test plan
All scenarios use `IMG_WIDTH=4`, `LINES=2`, `WIDTH=8`, pixel value = row*16+col, with `sof` on the first pixel.

1. Three continuous rows:
   - `valid_out` is 0 for rows 0–1.
   - First `valid_out` is the cycle after pixel 0x20, with `taps_out` = {0x00,0x10,0x20} (slice2..slice0) and `col_out` = 0.
   - `eol_out` is 1 with taps {0x03,0x13,0x23}.
2. Random `valid_in` gaps (50%) over 5 rows:
   - Output sequence is identical to the gapless run.
   - `valid_out` never asserts without a preceding `valid_in`.
3. Rows 0–3 streamed:
   - Row 3 col 1 gives taps {0x11,0x21,0x31}, proving the vertical shift.
4. `sof` at row 2 col 2 (with `valid_in`, new pixel 0x00):
   - No `valid_out` until new row 2.
   - Then taps {0x00,0x10,0x20} from new-frame data only.
5. `rst_n` pulsed low at row 3 col 1:
   - All outputs are 0 during reset.
   - Restreaming from row 0 reproduces scenario 1 exactly.
6. `sof` alone (no `valid_in`) mid-frame, then a normal frame:
   - Column restarts at 0.
   - First valid taps appear after two full rows.
